sram_line_seq: RTL
==================

SRAM_LINE_SEQ -- requirements
Module: sram_line_seq

Interface
REQ-001 Parameter ACC_CYC, default 2, clock cycles per 16-bit SRAM beat (legal range 2..15).
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 i_ADDR  input  32  halfword address of the line; only [17:3] are used, [2:0] ignored (line is 8-halfword aligned).
REQ-005 i_WDATA  input  128  write line; halfword k = i_WDATA[16k+15:16k].
REQ-006 i_WREN  input  1  line write request.
REQ-007 i_RDEN  input  1  line read request.
REQ-008 o_RDATA  output  128  read line; halfword k from SRAM address {base,k}.
REQ-009 o_ACK  output  1  one-cycle completion pulse.
REQ-010 o_ERR  output  1  out-of-range flag, qualified by o_ACK.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM halfword address.
REQ-013 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  output  1 each  active-low SRAM controls.

Function
REQ-014 FSM states: IDLE, WRITE, READ, DONE.
REQ-015 IDLE: when i_WREN|i_RDEN is sampled high, i_ADDR[17:3] and i_WDATA are latched, beat and cycle counters clear, next state WRITE if i_WREN else READ.
REQ-016 If i_WREN and i_RDEN are both high, the write wins.
REQ-017 Requests are ignored outside IDLE; the latched data is not disturbed.
REQ-018 WRITE/READ: beat counter 0..7 with cycle counter 0..ACC_CYC-1; SRAM_ADDR = {base[14:0], beat}.
REQ-019 During WRITE/READ: CE_N, LB_N and UB_N are 0.
REQ-020 WRITE beat: DQ driven with latched halfword[beat] on every cycle of the beat; WE_N=0 on cycles 0..ACC_CYC-2 and 1 on the last cycle (hold); OE_N=1.
REQ-021 READ beat: OE_N=0, WE_N=1, DQ high-Z; DQ is sampled into o_RDATA[16*beat+15:16*beat] on the last cycle of the beat.
REQ-022 After the last cycle of beat 7, next state is DONE; DONE asserts o_ACK for exactly one cycle, then returns to IDLE.
REQ-023 Latency: request sampled at edge t gives o_ACK high in the cycle after edge t+8*ACC_CYC; a request held high is re-accepted on the IDLE cycle following DONE.
REQ-024 o_RDATA holds its value from DONE until the next read overwrites it, halfword by halfword; writes leave o_RDATA unchanged.
REQ-025 IDLE and DONE: CE_N=OE_N=WE_N=LB_N=UB_N=1, DQ high-Z, SRAM_ADDR holds its last value.
REQ-026 DQ is never driven while OE_N=0.

Reset
REQ-027 On rst_ni=0 at a clock edge: state=IDLE, counters=0, o_RDATA=0, o_ACK=0, o_ERR=0, SRAM_ADDR=0, all SRAM controls=1, DQ high-Z.
REQ-028 Reset mid-transfer aborts immediately with no o_ACK; a partial write is left in the SRAM as-is.

Configuration
REQ-029 Macro SRAM_LINE_RANGE_CHK_EN.
REQ-030 With the macro defined, a request with i_ADDR[31:18]!=0 skips WRITE/READ, goes straight from IDLE to DONE, pulses o_ACK with o_ERR=1, leaves o_RDATA unchanged and issues no SRAM access.
REQ-031 Without the macro, i_ADDR[31:18] is ignored (the address wraps into 18 bits), o_ERR is tied to 0, and the range logic is absent.

Verification
REQ-032 Reset, then i_WREN=1 with i_ADDR=0x10, i_WDATA=0x0007_0006_0005_0004_0003_0002_0001_0000, ACC_CYC=2 -> SRAM_ADDR runs 0x10..0x17 with data 0x0000..0x0007, WE_N pattern 0,1 per beat, o_ACK on cycle 17 after the accept.
REQ-033 SRAM model preloaded, i_RDEN=1 with i_ADDR=0x10 -> o_RDATA=0x0007_0006_0005_0004_0003_0002_0001_0000, one o_ACK pulse, and no DQ drive while OE_N=0.
REQ-034 i_WREN=i_RDEN=1 with i_ADDR=0x2F -> write performed at base 0x28; a second request raised during the transfer is ignored, and i_WDATA changed mid-transfer does not alter the SRAM contents.
REQ-035 rst_ni pulled low during beat 3 of a read -> the next cycle shows all controls=1, o_ACK=0, o_RDATA=0, state IDLE.
REQ-036 Macro defined, i_RDEN with i_ADDR=0x0004_0000 -> o_ACK=1 and o_ERR=1 two cycles after the request, CE_N stays 1 throughout; macro undefined -> normal read of SRAM 0x00000..0x00007.
REQ-037 Held i_RDEN across two transfers -> exactly one idle cycle between the DONE state and the next beat 0.

Source files
------------

// File: rtl/sram_line_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sram_line_seq
//  Purpose  : Moves one 8-halfword (128-bit) line between a host port and an
//             asynchronous 16-bit SRAM, one halfword beat at a time, with
//             ACC_CYC clock cycles per beat. Completion is a one-cycle o_ACK.
//  Options  : SRAM_LINE_RANGE_CHK_EN - when defined, requests whose address
//             has any of bits [31:18] set complete at once with o_ERR=1 and
//             touch neither the SRAM nor o_RDATA.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_line_seq #(
    parameter int ACC_CYC = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [31:0]  i_ADDR,
    input  logic [127:0] i_WDATA,
    input  logic         i_WREN,
    input  logic         i_RDEN,
    output logic [127:0] o_RDATA,
    output logic         o_ACK,
    output logic         o_ERR,
    inout  wire  [15:0]  SRAM_DQ,
    output logic [17:0]  SRAM_ADDR,
    output logic         SRAM_CE_N,
    output logic         SRAM_OE_N,
    output logic         SRAM_WE_N,
    output logic         SRAM_LB_N,
    output logic         SRAM_UB_N
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_last_cyc = 4'(ACC_CYC - 1);

    state_t       r_state;
    logic [14:0]  r_base;
    logic [127:0] r_wdata;
    logic [2:0]   r_beat;
    logic [3:0]   r_cyc;
    logic         r_dq_oe;
    logic [15:0]  r_dq_out;

    logic         w_req;
    logic         w_last_cyc;
    logic [2:0]   w_beat_nxt;
    logic [3:0]   w_cyc_nxt;
    logic         w_unused;

    assign w_req      = i_WREN | i_RDEN;
    assign w_last_cyc = (r_cyc == c_last_cyc);
    assign w_beat_nxt = r_beat + 3'd1;
    assign w_cyc_nxt  = r_cyc + 4'd1;

`ifdef SRAM_LINE_RANGE_CHK_EN
    assign w_unused = ^i_ADDR[2:0];
`else
    // The upper address bits simply wrap away and there is never an error.
    assign w_unused = ^{i_ADDR[31:18], i_ADDR[2:0]};
    assign o_ERR    = 1'b0;
`endif

    // The bus is only ever driven during write beats, which keep OE_N high.
    assign SRAM_DQ = r_dq_oe ? r_dq_out : 16'hzzzz;

    // Line sequencer: all SRAM controls and host outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_base    <= 15'd0;
            r_wdata   <= 128'd0;
            r_beat    <= 3'd0;
            r_cyc     <= 4'd0;
            r_dq_oe   <= 1'b0;
            r_dq_out  <= 16'd0;
            o_RDATA   <= 128'd0;
            o_ACK     <= 1'b0;
`ifdef SRAM_LINE_RANGE_CHK_EN
            o_ERR     <= 1'b0;
`endif
            SRAM_ADDR <= 18'd0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_ACK <= 1'b0;
                    if (w_req) begin
                        r_base  <= i_ADDR[17:3];
                        r_wdata <= i_WDATA;
                        r_beat  <= 3'd0;
                        r_cyc   <= 4'd0;
`ifdef SRAM_LINE_RANGE_CHK_EN
                        if (|i_ADDR[31:18]) begin
                            r_state <= ST_DONE;
                            o_ACK   <= 1'b1;
                            o_ERR   <= 1'b1;
                        end else
`endif
                        begin
                            SRAM_ADDR <= {i_ADDR[17:3], 3'd0};
                            SRAM_CE_N <= 1'b0;
                            SRAM_LB_N <= 1'b0;
                            SRAM_UB_N <= 1'b0;
                            if (i_WREN) begin
                                // Write has priority when both requests are up.
                                r_state   <= ST_WRITE;
                                SRAM_WE_N <= 1'b0;
                                SRAM_OE_N <= 1'b1;
                                r_dq_oe   <= 1'b1;
                                r_dq_out  <= i_WDATA[15:0];
                            end else begin
                                r_state   <= ST_READ;
                                SRAM_WE_N <= 1'b1;
                                SRAM_OE_N <= 1'b0;
                                r_dq_oe   <= 1'b0;
                            end
                        end
                    end
                end

                ST_WRITE, ST_READ: begin
                    if (w_last_cyc) begin
                        if (r_state == ST_READ) begin
                            o_RDATA[{r_beat, 4'd0} +: 16] <= SRAM_DQ;
                        end
                        r_cyc <= 4'd0;
                        if (r_beat == 3'd7) begin
                            r_state   <= ST_DONE;
                            o_ACK     <= 1'b1;
                            SRAM_CE_N <= 1'b1;
                            SRAM_OE_N <= 1'b1;
                            SRAM_WE_N <= 1'b1;
                            SRAM_LB_N <= 1'b1;
                            SRAM_UB_N <= 1'b1;
                            r_dq_oe   <= 1'b0;
                        end else begin
                            r_beat    <= w_beat_nxt;
                            SRAM_ADDR <= {r_base, w_beat_nxt};
                            if (r_state == ST_WRITE) begin
                                SRAM_WE_N <= 1'b0;
                                r_dq_out  <= r_wdata[{w_beat_nxt, 4'd0} +: 16];
                            end
                        end
                    end else begin
                        r_cyc <= w_cyc_nxt;
                        // WE_N rises for the final cycle of a beat so data is held past the strobe.
                        if (r_state == ST_WRITE) begin
                            SRAM_WE_N <= (w_cyc_nxt == c_last_cyc);
                        end
                    end
                end

                ST_DONE: begin
                    o_ACK   <= 1'b0;
`ifdef SRAM_LINE_RANGE_CHK_EN
                    o_ERR   <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
